// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage: FSM states,
// next-PC source selection, NOP encoding and default vector/drain depth.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SERVICE
  } fetch_state_t;

  typedef enum logic [2:0] {
    PC_INC,
    PC_TARGET,
    PC_VECTOR,
    PC_EPC,
    PC_HOLD
  } pc_sel_t;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_ISR_VECTOR   = 32'h0000_0080;
  localparam int unsigned DEFAULT_DRAIN_CYCLES = 3;
  localparam int unsigned CNT_W                = 8;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
// The master modport is the fetch stage; slave is the surrounding pipeline.
interface instruction_fetch_stage_if;
  logic [31:0] PC_in;
  logic        Branch_s;
  logic        Stall;
  logic        Flush;
  logic        IE;
  logic        irq;
  logic        leave_isr;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_IR;
  logic [31:0] PC_out;
  logic        ISR;
  logic [31:0] EPC;

  modport master (
    input  PC_in, Branch_s, Stall, Flush, IE, irq, leave_isr, imem_rdata,
    output imem_addr, IFID_IR, PC_out, ISR, EPC
  );

  modport slave (
    output PC_in, Branch_s, Stall, Flush, IE, irq, leave_isr, imem_rdata,
    input  imem_addr, IFID_IR, PC_out, ISR, EPC
  );
endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential, redirect target, ISR vector,
// saved return address or hold, prioritised by FSM state and hazard controls.
module pc_next_mux
  import fetch_pkg::*;
#(
  parameter logic [31:0] ISR_VECTOR = DEFAULT_ISR_VECTOR
) (
  input  fetch_state_t state,
  input  logic         branch,
  input  logic         stall,
  input  logic         take_irq,
  input  logic         drain_done,
  input  logic         leave,
  input  logic [31:0]  pc,
  input  logic [31:0]  pc_in,
  input  logic [31:0]  epc,
  output logic [31:0]  pc_next
);

  pc_sel_t sel;

  always_comb begin
    sel = PC_HOLD;
    if (state == DRAIN) begin
      sel = drain_done ? PC_VECTOR : PC_HOLD;
    end else if (state == SERVICE && leave) begin
      sel = PC_EPC;
    end else if (branch) begin
      sel = PC_TARGET;
    end else if (take_irq || stall) begin
      sel = PC_HOLD;
    end else begin
      sel = PC_INC;
    end
  end

  always_comb begin
    pc_next = pc;
    unique case (sel)
      PC_INC:    pc_next = pc + 32'd4;
      PC_TARGET: pc_next = pc_in;
      PC_VECTOR: pc_next = ISR_VECTOR;
      PC_EPC:    pc_next = epc;
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Pipeline stage 1: program counter, IF/ID register, and the interrupt
// entry/exit sequencer (drain, vector fetch, return to EPC).
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter logic [31:0] ISR_VECTOR   = DEFAULT_ISR_VECTOR,
  parameter int unsigned DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input logic                        clk,
  input logic                        rst,
  instruction_fetch_stage_if.master  bus
);

  fetch_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      pc, pc_n;
  logic [31:0]      ir, ir_n;
  logic [31:0]      pc_out, pc_out_n;
  logic [31:0]      epc, epc_n;
  logic             take_irq;
  logic             drain_done;

  assign take_irq   = (state == RUN) && bus.irq && bus.IE && !bus.Stall;
  assign drain_done = (state == DRAIN) && (cnt == '0) && !bus.Stall;

  pc_next_mux #(.ISR_VECTOR(ISR_VECTOR)) u_pc_next_mux (
    .state      (state),
    .branch     (bus.Branch_s),
    .stall      (bus.Stall),
    .take_irq   (take_irq),
    .drain_done (drain_done),
    .leave      (bus.leave_isr),
    .pc         (pc),
    .pc_in      (bus.PC_in),
    .epc        (epc),
    .pc_next    (pc_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      pc     <= RESET_PC;
      ir     <= NOP_INSTR;
      pc_out <= '0;
      epc    <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pc     <= pc_n;
      ir     <= ir_n;
      pc_out <= pc_out_n;
      epc    <= epc_n;
    end
  end

  // A NOP load clears both halves of IF/ID so decode never sees a stale PC.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ir_n     = ir;
    pc_out_n = pc_out;
    epc_n    = epc;
    unique case (state)
      DRAIN: begin
        ir_n     = NOP_INSTR;
        pc_out_n = '0;
        if (bus.Branch_s) epc_n = bus.PC_in;
        if (!bus.Stall) begin
          if (cnt == '0) state_n = SERVICE;
          else           cnt_n   = cnt - 1'b1;
        end
      end
      default: begin
        if (state == SERVICE && bus.leave_isr) begin
          ir_n     = NOP_INSTR;
          pc_out_n = '0;
          state_n  = RUN;
        end else if (bus.Branch_s) begin
          ir_n     = NOP_INSTR;
          pc_out_n = '0;
        end else if (take_irq) begin
          epc_n    = pc;
          ir_n     = NOP_INSTR;
          pc_out_n = '0;
          cnt_n    = CNT_W'(DRAIN_CYCLES - 1);
          state_n  = DRAIN;
        end else if (bus.Stall || bus.Flush) begin
          if (bus.Flush) begin
            ir_n     = NOP_INSTR;
            pc_out_n = '0;
          end
        end else begin
          ir_n     = bus.imem_rdata;
          pc_out_n = pc + 32'd4;
        end
      end
    endcase
  end

  assign bus.imem_addr = pc;
  assign bus.IFID_IR   = ir;
  assign bus.PC_out    = pc_out;
  assign bus.ISR       = (state == SERVICE);
  assign bus.EPC       = epc;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed per-cycle vectors
// push hand-computed outputs; a negedge monitor pops and compares them.
module tb_instruction_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage #(
    .RESET_PC     (32'h0000_0000),
    .ISR_VECTOR   (32'h0000_0080),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // instruction memory returns its own address as data
  always_comb bus.imem_rdata = bus.imem_addr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] pco;
    logic        isr;
    logic [31:0] epc;
    logic [4:0]  chk;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  localparam logic [4:0] K_ALL   = 5'b11111;
  localparam logic [4:0] K_NOPCO = 5'b11011;

  localparam logic [6:0] C_RST = 7'b1000000;
  localparam logic [6:0] C_BR  = 7'b0100000;
  localparam logic [6:0] C_ST  = 7'b0010000;
  localparam logic [6:0] C_FL  = 7'b0001000;
  localparam logic [6:0] C_IE  = 7'b0000100;
  localparam logic [6:0] C_IRQ = 7'b0000010;
  localparam logic [6:0] C_LV  = 7'b0000001;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk[4]) check("imem_addr", e.cyc, bus.imem_addr, e.addr);
        if (e.chk[3]) check("IFID_IR",   e.cyc, bus.IFID_IR,   e.ir);
        if (e.chk[2]) check("PC_out",    e.cyc, bus.PC_out,    e.pco);
        if (e.chk[1]) check("ISR",       e.cyc, {31'd0, bus.ISR}, {31'd0, e.isr});
        if (e.chk[0]) check("EPC",       e.cyc, bus.EPC,       e.epc);
      end
    end
  end

  // Wait for the next edge, queue the outputs expected in this cycle, then
  // drive the controls that take effect at the following edge.
  task automatic cyc(input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                     input logic eisr, input logic [31:0] ee, input logic [4:0] chk,
                     input logic [6:0] ctl, input logic [31:0] pin);
    exp_t e;
    @(posedge clk);
    #1;
    e.addr = ea; e.ir = ei; e.pco = ep; e.isr = eisr; e.epc = ee; e.chk = chk; e.cyc = cyc_no;
    sb.push_back(e);
    rst           = ctl[6];
    bus.Branch_s  = ctl[5];
    bus.Stall     = ctl[4];
    bus.Flush     = ctl[3];
    bus.IE        = ctl[2];
    bus.irq       = ctl[1];
    bus.leave_isr = ctl[0];
    bus.PC_in     = pin;
    cyc_no++;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.PC_in = '0; bus.Branch_s = 0; bus.Stall = 0; bus.Flush = 0;
    bus.IE = 0; bus.irq = 0; bus.leave_isr = 0;

    // reset state
    cyc(32'h0,   32'h0,  32'h0,  0, 32'h0, K_ALL, C_RST, 32'h0);
    cyc(32'h0,   32'h0,  32'h0,  0, 32'h0, K_ALL, 7'd0,  32'h0);
    // free run
    cyc(32'h4,   32'h0,  32'h4,  0, 32'h0, K_ALL, 7'd0,  32'h0);
    cyc(32'h8,   32'h4,  32'h8,  0, 32'h0, K_ALL, 7'd0,  32'h0);
    cyc(32'hC,   32'h8,  32'hC,  0, 32'h0, K_ALL, 7'd0,  32'h0);
    // stall two cycles at 0x10, then stall+flush
    cyc(32'h10,  32'hC,  32'h10, 0, 32'h0, K_ALL, C_ST,  32'h0);
    cyc(32'h10,  32'hC,  32'h10, 0, 32'h0, K_ALL, C_ST,  32'h0);
    cyc(32'h10,  32'hC,  32'h10, 0, 32'h0, K_ALL, C_ST | C_FL, 32'h0);
    cyc(32'h10,  32'h0,  32'h0,  0, 32'h0, K_NOPCO, 7'd0, 32'h0);
    cyc(32'h14,  32'h10, 32'h14, 0, 32'h0, K_ALL, 7'd0,  32'h0);
    cyc(32'h18,  32'h14, 32'h18, 0, 32'h0, K_ALL, 7'd0,  32'h0);
    cyc(32'h1C,  32'h18, 32'h1C, 0, 32'h0, K_ALL, 7'd0,  32'h0);
    // branch at 0x20, then branch under stall
    cyc(32'h20,  32'h1C, 32'h20, 0, 32'h0, K_ALL, C_BR,  32'h200);
    cyc(32'h200, 32'h0,  32'h0,  0, 32'h0, K_NOPCO, 7'd0, 32'h0);
    cyc(32'h204, 32'h200, 32'h204, 0, 32'h0, K_ALL, C_BR | C_ST, 32'h220);
    cyc(32'h220, 32'h0,  32'h0,  0, 32'h0, K_NOPCO, 7'd0, 32'h0);
    cyc(32'h224, 32'h220, 32'h224, 0, 32'h0, K_ALL, C_BR, 32'h40);
    // interrupt at 0x40: drain, vector, service
    cyc(32'h40,  32'h0,  32'h0,  0, 32'h0,  K_NOPCO, C_IE | C_IRQ, 32'h0);
    cyc(32'h40,  32'h0,  32'h0,  0, 32'h40, K_NOPCO, C_IE, 32'h0);
    cyc(32'h40,  32'h0,  32'h0,  0, 32'h40, K_NOPCO, C_IE, 32'h0);
    cyc(32'h40,  32'h0,  32'h0,  0, 32'h40, K_NOPCO, C_IE, 32'h0);
    cyc(32'h80,  32'h0,  32'h0,  1, 32'h40, K_NOPCO, C_IE, 32'h0);
    cyc(32'h84,  32'h80, 32'h84, 1, 32'h40, K_ALL, C_IE | C_IRQ, 32'h0);
    // leave_isr beats a simultaneous branch
    cyc(32'h88,  32'h84, 32'h88, 1, 32'h40, K_ALL, C_IE | C_LV | C_BR, 32'h500);
    cyc(32'h40,  32'h0,  32'h0,  0, 32'h40, K_NOPCO, C_IRQ, 32'h0);
    // IE=0 ignored above; leave_isr in RUN ignored here
    cyc(32'h44,  32'h40, 32'h44, 0, 32'h40, K_ALL, C_IE | C_LV, 32'h0);
    cyc(32'h48,  32'h44, 32'h48, 0, 32'h40, K_ALL, C_IE | C_IRQ, 32'h0);
    // branch during drain updates EPC; stall freezes the drain counter
    cyc(32'h48,  32'h0,  32'h0,  0, 32'h48,  K_NOPCO, C_IE | C_BR, 32'h300);
    cyc(32'h48,  32'h0,  32'h0,  0, 32'h300, K_NOPCO, C_IE | C_ST, 32'h0);
    cyc(32'h48,  32'h0,  32'h0,  0, 32'h300, K_NOPCO, C_IE, 32'h0);
    cyc(32'h48,  32'h0,  32'h0,  0, 32'h300, K_NOPCO, C_IE, 32'h0);
    cyc(32'h80,  32'h0,  32'h0,  1, 32'h300, K_NOPCO, C_IE | C_LV, 32'h0);
    cyc(32'h300, 32'h0,  32'h0,  0, 32'h300, K_NOPCO, C_IE, 32'h0);
    cyc(32'h304, 32'h300, 32'h304, 0, 32'h300, K_ALL, C_IE | C_IRQ, 32'h0);
    cyc(32'h304, 32'h0,  32'h0,  0, 32'h304, K_NOPCO, C_IE, 32'h0);
    cyc(32'h304, 32'h0,  32'h0,  0, 32'h304, K_NOPCO, C_IE, 32'h0);
    cyc(32'h304, 32'h0,  32'h0,  0, 32'h304, K_NOPCO, C_IE, 32'h0);
    // reset while in service
    cyc(32'h80,  32'h0,  32'h0,  1, 32'h304, K_NOPCO, C_IE | C_RST, 32'h0);
    cyc(32'h0,   32'h0,  32'h0,  0, 32'h0,   K_ALL, C_BR, 32'hFFFF_FFFC);
    // PC wrap, then flush alone
    cyc(32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'h0, K_NOPCO, 7'd0, 32'h0);
    cyc(32'h0,   32'hFFFF_FFFC, 32'h0, 0, 32'h0, K_ALL, C_FL, 32'h0);
    cyc(32'h4,   32'h0,  32'h0,  0, 32'h0,   K_NOPCO, 7'd0, 32'h0);
    cyc(32'h8,   32'h4,  32'h8,  0, 32'h0,   K_ALL, 7'd0, 32'h0);

    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Stage 1 of the pipelined MIPS core: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register (`IFID_IR`, `PC_out`) consumed by the decode stage. It accepts the redirect (`PC_in`, `Branch_s`) and hazard controls (`Stall`, `Flush`) returned from later stages. It also sequences interrupt entry and exit: pipeline drain, vector fetch, and return to the saved PC.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `ISR_VECTOR`, 32'h0000_0080, first fetch address of the service routine
- `DRAIN_CYCLES`, 3, NOP cycles inserted before vectoring (IF→MEM depth)
- `clk` in 1 — single clock; all state updates on rising edge
- `rst` in 1 — reset is synchronous and active-high
- `PC_in` in 32 — branch/jump target from memory stage
- `Branch_s` in 1 — take `PC_in` this cycle
- `Stall` in 1 — hold PC and IF/ID
- `Flush` in 1 — load NOP into IF/ID
- `IE` in 1 — interrupt enable
- `irq` in 1 — level interrupt request
- `leave_isr` in 1 — one-cycle pulse: return from service routine
- `imem_addr` out 32 — instruction-memory address (= PC, combinational)
- `imem_rdata` in 32 — instruction word, valid same cycle as `imem_addr`
- `IFID_IR` out 32 — fetched instruction to decode
- `PC_out` out 32 — address of `IFID_IR` + 4
- `ISR` out 1 — high while in service routine
- `EPC` out 32 — saved return address

## Operation
- States: RUN, DRAIN, SERVICE.
- RUN, priority high→low:
  - `Branch_s`: PC←`PC_in`; IF/ID←NOP.
  - Interrupt take (`irq & IE & !Stall`): EPC←PC; IF/ID←NOP; cnt←`DRAIN_CYCLES`-1; →DRAIN. PC holds.
  - `Stall`: PC and IF/ID hold. If `Flush` is also high, IF/ID←NOP and PC holds.
  - `Flush` alone: IF/ID←NOP; PC←PC+4.
  - Normal: IF/ID←{`imem_rdata`, PC+4}; PC←PC+4.
- DRAIN:
  - IF/ID←NOP every cycle.
  - PC holds.
  - `Branch_s` updates EPC←`PC_in`, so a redirect in flight is not lost.
  - `Stall` freezes cnt.
  - At cnt=0 with no `Stall`: PC←`ISR_VECTOR`; →SERVICE.
- SERVICE:
  - Fetch behaves as in RUN, except that `irq` is ignored (no nesting).
  - `ISR`=1.
  - `leave_isr`: PC←EPC; IF/ID←NOP; →RUN. `leave_isr` beats `Branch_s` in the same cycle.
- `leave_isr` outside SERVICE is ignored.
- NOP = 32'h0000_0000. PC arithmetic is modulo 2^32; PC+4 wraps from FFFF_FFFC to 0.

## Timing
- Reset values: PC=`RESET_PC`; `IFID_IR`=0; `PC_out`=0; `EPC`=0; `ISR`=0; state RUN; cnt=0. `imem_addr`=`RESET_PC`.
- Fetch latency is 1 cycle: the address presented in cycle n appears on `IFID_IR` after edge n.
- Redirect latency is 1 cycle: `Branch_s` in cycle n puts the target on `imem_addr` in cycle n+1, and that instruction reaches `IFID_IR` after edge n+1.
- Interrupt latency, no stalls: take at edge n, vector on `imem_addr` at cycle n+`DRAIN_CYCLES`, `ISR` rises at the same edge.
- `rst` mid-DRAIN or mid-SERVICE: immediate return to reset values; EPC is lost.
- `irq` is level-sensitive. An `irq` still high on return to RUN is retaken on the first eligible cycle.

## Structure
- Shared package `fetch_pkg`: state enum (RUN/DRAIN/SERVICE), `NOP_INSTR`, default `ISR_VECTOR`, `DRAIN_CYCLES`.
- One natural sub-module: `pc_next_mux`. It is combinational and selects among PC+4, `PC_in`, `ISR_VECTOR`, EPC and hold from the state and control signals.
- The FSM, cnt, EPC and IF/ID registers stay in the top module.

## Test plan
- Reset, then free run with imem returning address-as-data: `IFID_IR` = 0, 4, 8… and `PC_out` = 4, 8, C…
- `Stall` for 2 cycles at PC=0x10: `imem_addr` stays 0x10 and `IFID_IR` holds 0x0C. `Stall`+`Flush` together gives `IFID_IR`=0 with PC held.
- `Branch_s` with `PC_in`=0x200 at PC=0x20: next `imem_addr`=0x200 and `IFID_IR`=NOP for one cycle. Repeat with `Stall` asserted: the branch still wins.
- `irq` with `IE`=1 at PC=0x40: three NOPs, then `imem_addr`=0x80, `ISR`=1, `EPC`=0x40. Repeat with `IE`=0: no effect.
- During DRAIN, `Branch_s` with `PC_in`=0x300 sets `EPC`=0x300. A later `leave_isr` gives `imem_addr`=0x300 and `ISR`=0.
- `rst` asserted in SERVICE: next cycle `imem_addr`=`RESET_PC`, `ISR`=0, `EPC`=0. PC at FFFF_FFFC wraps to 0.
